pipelined_cpu_core: RTL

Parametrised successor to the five-stage pipelined CPU: fetch, decode, execute, memory, writeback. It is generalised in data and address width and keeps full forwarding. It adds a load-use interlock, taken-branch/jump flush, a hardwired zero register, and a ready handshake on the data bus that freezes the whole pipeline during memory wait states. It sits between the instruction memory and the data memory at top level and replaces the fixed-width core.

---
 rtl/pipelined_cpu_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cpu_core.sv
// Five-stage pipelined CPU core (fetch, decode, execute, memory, writeback)
// with full forwarding into decode, load-use interlock, branch flush and a data-bus freeze.
module pipelined_cpu_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic [31:0]           i_instruction,
  output logic                  o_mem_valid,
  output logic                  o_mem_rw,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ready,
  output logic                  o_stall,
  output logic                  o_freeze,
  output logic                  o_flush
);

  typedef enum logic [2:0] {
    OP_NOP, OP_LW, OP_SW, OP_ADD, OP_SUB, OP_ADDI, OP_BEQ, OP_JMP
  } op_e;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  op_e                   de_op_q, de_op_d;
  logic [3:0]            de_rd_q, de_rd_d;
  logic [DATA_WIDTH-1:0] de_a_q, de_a_d, de_b_q, de_b_d, de_imm_q, de_imm_d;
  op_e                   em_op_q, em_op_d;
  logic [3:0]            em_rd_q, em_rd_d;
  logic [DATA_WIDTH-1:0] em_alu_q, em_alu_d, em_sdata_q, em_sdata_d;
  logic                  mw_we_q, mw_we_d;
  logic [3:0]            mw_rd_q, mw_rd_d;
  logic [DATA_WIDTH-1:0] mw_val_q, mw_val_d;
  logic [DATA_WIDTH-1:0] rf_q [16];
  logic [DATA_WIDTH-1:0] rf_d [16];

  op_e                   d_op;
  logic [3:0]            d_rd, d_rs1, d_rs2;
  logic [DATA_WIDTH-1:0] d_imm, d_opnd_a, d_opnd_b;
  logic                  d_use1, d_use2;
  logic [DATA_WIDTH-1:0] ex_alu, m_val;
  logic                  ex_fwd, ex_taken, m_we, load_use;

  always_comb begin
    d_rd  = ir_q[23:20];
    d_rs1 = ir_q[19:16];
    d_rs2 = ir_q[15:12];
    d_imm = DATA_WIDTH'($signed(ir_q[15:0]));
    case (ir_q[31:24])
      8'd1:    d_op = OP_LW;
      8'd2:    d_op = OP_SW;
      8'd3:    d_op = OP_ADD;
      8'd4:    d_op = OP_SUB;
      8'd5:    d_op = OP_ADDI;
      8'd6:    d_op = OP_BEQ;
      8'd7:    d_op = OP_JMP;
      default: d_op = OP_NOP;
    endcase
    d_use1 = d_op inside {OP_LW, OP_SW, OP_ADD, OP_SUB, OP_ADDI, OP_BEQ};
    d_use2 = d_op inside {OP_SW, OP_ADD, OP_SUB, OP_BEQ};
  end

  always_comb begin
    case (de_op_q)
      OP_ADD:               ex_alu = de_a_q + de_b_q;
      OP_SUB:               ex_alu = de_a_q - de_b_q;
      OP_ADDI, OP_LW, OP_SW: ex_alu = de_a_q + de_imm_q;
      default:              ex_alu = '0;
    endcase
    ex_fwd   = de_op_q inside {OP_ADD, OP_SUB, OP_ADDI};
    ex_taken = (de_op_q == OP_JMP) || ((de_op_q == OP_BEQ) && (de_a_q == de_b_q));
    m_we     = em_op_q inside {OP_LW, OP_ADD, OP_SUB, OP_ADDI};
    m_val    = (em_op_q == OP_LW) ? i_mem_rdata : em_alu_q;
  end

  // Youngest producer wins; r0 never takes a forwarded value.
  function automatic logic [DATA_WIDTH-1:0] fwd(input logic [3:0] rs);
    if (rs == 4'd0)                     return '0;
    else if (ex_fwd && de_rd_q == rs)   return ex_alu;
    else if (m_we && em_rd_q == rs)     return m_val;
    else if (mw_we_q && mw_rd_q == rs)  return mw_val_q;
    else                                return rf_q[rs];
  endfunction

  always_comb begin
    d_opnd_a = fwd(d_rs1);
    d_opnd_b = fwd(d_rs2);
    load_use = (de_op_q == OP_LW) && (de_rd_q != 4'd0) &&
               ((d_use1 && d_rs1 == de_rd_q) || (d_use2 && d_rs2 == de_rd_q));
    o_mem_valid = em_op_q inside {OP_LW, OP_SW};
    o_mem_rw    = (em_op_q == OP_SW);
    o_mem_addr  = o_mem_valid ? em_alu_q[ADDR_WIDTH-1:0] : '0;
    o_mem_wdata = o_mem_rw ? em_sdata_q : '0;
    o_freeze    = o_mem_valid && !i_mem_ready;
    o_flush     = ex_taken && !o_freeze;
    o_stall     = load_use && !ex_taken && !o_freeze;
    o_pc        = pc_q;
  end

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    de_op_d    = de_op_q;
    de_rd_d    = de_rd_q;
    de_a_d     = de_a_q;
    de_b_d     = de_b_q;
    de_imm_d   = de_imm_q;
    em_op_d    = em_op_q;
    em_rd_d    = em_rd_q;
    em_alu_d   = em_alu_q;
    em_sdata_d = em_sdata_q;
    mw_we_d    = mw_we_q;
    mw_rd_d    = mw_rd_q;
    mw_val_d   = mw_val_q;
    rf_d       = rf_q;
    if (!o_freeze) begin
      mw_we_d    = m_we;
      mw_rd_d    = em_rd_q;
      mw_val_d   = m_val;
      em_op_d    = de_op_q;
      em_rd_d    = de_rd_q;
      em_alu_d   = ex_alu;
      em_sdata_d = de_b_q;
      if (o_flush || o_stall) begin
        de_op_d  = OP_NOP;
        de_rd_d  = '0;
        de_a_d   = '0;
        de_b_d   = '0;
        de_imm_d = '0;
      end else begin
        de_op_d  = d_op;
        de_rd_d  = d_rd;
        de_a_d   = d_opnd_a;
        de_b_d   = d_opnd_b;
        de_imm_d = d_imm;
      end
      if (o_flush) begin
        pc_d = de_imm_q[ADDR_WIDTH-1:0];
        ir_d = '0;
      end else if (!o_stall) begin
        pc_d = pc_q + ADDR_WIDTH'(4);
        ir_d = i_instruction;
      end
      if (mw_we_q && mw_rd_q != 4'd0) rf_d[mw_rd_q] = mw_val_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q       <= '0;
      ir_q       <= '0;
      de_op_q    <= OP_NOP;
      de_rd_q    <= '0;
      de_a_q     <= '0;
      de_b_q     <= '0;
      de_imm_q   <= '0;
      em_op_q    <= OP_NOP;
      em_rd_q    <= '0;
      em_alu_q   <= '0;
      em_sdata_q <= '0;
      mw_we_q    <= 1'b0;
      mw_rd_q    <= '0;
      mw_val_q   <= '0;
      rf_q       <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      de_op_q    <= de_op_d;
      de_rd_q    <= de_rd_d;
      de_a_q     <= de_a_d;
      de_b_q     <= de_b_d;
      de_imm_q   <= de_imm_d;
      em_op_q    <= em_op_d;
      em_rd_q    <= em_rd_d;
      em_alu_q   <= em_alu_d;
      em_sdata_q <= em_sdata_d;
      mw_we_q    <= mw_we_d;
      mw_rd_q    <= mw_rd_d;
      mw_val_q   <= mw_val_d;
      rf_q       <= rf_d;
    end
  end

endmodule
